gift_tracker_fsm: RTL and testbench
===================================

Name: gift_tracker_fsm

Overview:
- Game-level state machine directly downstream of the collision stage.
- Consumes per-pixel gift overlap and the once-per-frame hole hit.
- Counts collected gifts once per frame and issues the gift_clear pulse that the collision stage and tile memory consume.
- Reveals the hole when all gifts are taken, runs the level countdown, and decides win or lose.

Parameters:
- NUM_GIFTS, 5, gifts placed per level; loaded into gifts_left on level start; 1..15.
- FRAMES_PER_SEC, 30, startOfFrame pulses per countdown second.
- TIME_LIMIT_SEC, 60, level time budget in seconds; 1..127.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- startOfFrame  in  1  one-cycle pulse at the start of each frame
- start_btn  in  1  start/restart key, already synchronous to clk, level
- gift_hit  in  1  level; ball pixel overlaps a gift tile (collision-stage WriteEn)
- hole_hit  in  1  one-cycle pulse; ball hit the hole tile (collision-stage victory)
- gift_clear  out  1  one-cycle pulse; erase the touched gift tile
- gifts_left  out  4  gifts remaining in the current level
- show_hole  out  1  hole tile visible and active
- game_state  out  2  IDLE=0, PLAY=1, WIN=2, LOSE=3
- time_left  out  7  seconds remaining

Behaviour:
- Reset (synchronous, highest priority, also mid-game): game_state=IDLE, gifts_left=0, time_left=0, gift_clear=0, show_hole=0; frame counter, gift latch and start-edge register cleared.
- Start edge: start_rise = start_btn & ~start_btn_d (registered previous value).
- IDLE: on start_rise, go to PLAY next cycle and load:
  - gifts_left=NUM_GIFTS
  - time_left=TIME_LIMIT_SEC
  - frame_cnt=0
  - gift latch cleared.
- PLAY, gift latch: gift_hit=1 on any cycle sets gift_seen. Multiple pixels in one frame count as one gift.
- PLAY, frame boundary: on startOfFrame, if gift_seen && gifts_left!=0:
  - gifts_left decrements in the same edge;
  - gift_clear=1 on the following cycle only (latency 1 from startOfFrame);
  - gift_seen is cleared on every startOfFrame.
- A gift_hit coinciding with startOfFrame sets the latch for the new frame, not the old one.
- gift_clear is never asserted outside PLAY. gifts_left saturates at 0.
- show_hole is combinational: (game_state==PLAY) && (gifts_left==0).
- Timer:
  - In PLAY, each startOfFrame increments frame_cnt.
  - When frame_cnt==FRAMES_PER_SEC-1, it wraps to 0 and time_left decrements.
  - A decrement reaching 0 forces LOSE on that same edge.
  - frame_cnt width = $clog2(FRAMES_PER_SEC).
- Win: hole_hit while show_hole=1 → WIN. hole_hit with show_hole=0 is ignored.
- Priority on the same edge: reset > WIN (hole_hit) > LOSE (timeout) > gift decrement.
- WIN/LOSE: counters frozen, outputs held, gift_hit and hole_hit ignored. start_rise → IDLE. A further start_rise → PLAY.
- A held start_btn does not retrigger; only edges count.
- A start_rise in PLAY is ignored.
- No output depends combinationally on gift_hit or hole_hit.

Decomposition:
- Package game_pkg holds:
  - typedef enum logic [1:0] game_state_t {IDLE, PLAY, WIN, LOSE};
  - tile-type localparams BACKGROUND=00, FLOOR=01, GIFT=10, HOLE=11, shared with the collision stage.
- Sub-module frame_timer owns frame_cnt and time_left.
  - Inputs: clk, reset, load, run, startOfFrame.
  - Outputs: time_left, expired_pulse.
- The FSM, gift latch and edge detect stay in gift_tracker_fsm.

Test Plan:
- Reset mid-PLAY with gifts_left=3, time_left=40 → next cycle game_state=0, gifts_left=0, time_left=0, gift_clear=0.
- IDLE, start_btn held high 100 cycles → exactly one transition to PLAY; gifts_left=5, time_left=60; no second load while held.
- PLAY, gift_hit high for 200 cycles within one frame, then startOfFrame → gifts_left 5→4; gift_clear high exactly one cycle, one cycle after the pulse.
- Collect 5 gifts over 5 frames → show_hole=1 after the fifth decrement. hole_hit before that (gifts_left=1) is ignored. hole_hit after it → game_state=2.
- FRAMES_PER_SEC=2, TIME_LIMIT_SEC=3, no gifts → time_left 3,2,1,0 every 2 frames; game_state=3 on the edge time_left hits 0. Further startOfFrame pulses leave time_left=0.
- hole_hit with show_hole=1 on the same edge as the expiry tick → WIN (2), not LOSE. Then start_rise → IDLE, and a second start_rise → PLAY with counters reloaded.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game-level types: FSM state encoding and the tile codes used by the
// collision stage and tile memory.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    WIN  = 2'd2,
    LOSE = 2'd3
  } game_state_t;

  localparam logic [1:0] BACKGROUND = 2'b00;
  localparam logic [1:0] FLOOR      = 2'b01;
  localparam logic [1:0] GIFT       = 2'b10;
  localparam logic [1:0] HOLE       = 2'b11;

endpackage

// File: rtl/frame_timer.sv
// Level countdown: divides startOfFrame into seconds and counts time_left down.
// expired_pulse flags the tick that takes time_left from 1 to 0.
module frame_timer #(
  parameter int FRAMES_PER_SEC = 30,
  parameter int TIME_LIMIT_SEC = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       run,
  input  logic       startOfFrame,
  output logic [6:0] time_left,
  output logic       expired_pulse
);

  localparam int FC_W = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAMES_PER_SEC - 1);

  logic [FC_W-1:0] frame_cnt;
  logic            sec_tick;

  assign sec_tick      = run && startOfFrame && (frame_cnt == FC_LAST);
  // Combinational so the FSM can enter LOSE on the same edge time_left hits 0.
  assign expired_pulse = sec_tick && (time_left == 7'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt <= '0;
      time_left <= 7'd0;
    end else if (load) begin
      frame_cnt <= '0;
      time_left <= 7'(TIME_LIMIT_SEC);
    end else if (run && startOfFrame) begin
      if (sec_tick) begin
        frame_cnt <= '0;
        if (time_left != 7'd0)
          time_left <= time_left - 7'd1;
      end else begin
        frame_cnt <= frame_cnt + FC_W'(1);
      end
    end
  end

endmodule

// File: rtl/gift_tracker_fsm.sv
// Game-level FSM behind the collision stage: counts gifts once per frame,
// pulses gift_clear, reveals the hole and decides win/lose against the timer.
module gift_tracker_fsm
  import game_pkg::*;
#(
  parameter int NUM_GIFTS      = 5,
  parameter int FRAMES_PER_SEC = 30,
  parameter int TIME_LIMIT_SEC = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       start_btn,
  input  logic       gift_hit,
  input  logic       hole_hit,
  output logic       gift_clear,
  output logic [3:0] gifts_left,
  output logic       show_hole,
  output logic [1:0] game_state,
  output logic [6:0] time_left
);

  game_state_t state;
  logic        start_btn_d;
  logic        gift_seen;
  logic        start_rise;
  logic        win_evt;
  logic        expired;
  logic        timer_load;
  logic        timer_run;

  assign start_rise = start_btn & ~start_btn_d;
  assign show_hole  = (state == PLAY) && (gifts_left == 4'd0);
  assign win_evt    = (state == PLAY) && hole_hit && show_hole;
  assign timer_load = (state == IDLE) && start_rise;
  // A win freezes the clock on the winning edge, even if a second tick lands there.
  assign timer_run  = (state == PLAY) && !win_evt;
  assign game_state = state;

  frame_timer #(
    .FRAMES_PER_SEC(FRAMES_PER_SEC),
    .TIME_LIMIT_SEC(TIME_LIMIT_SEC)
  ) u_frame_timer (
    .clk          (clk),
    .reset        (reset),
    .load         (timer_load),
    .run          (timer_run),
    .startOfFrame (startOfFrame),
    .time_left    (time_left),
    .expired_pulse(expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      start_btn_d <= 1'b0;
      gift_seen   <= 1'b0;
      gifts_left  <= 4'd0;
      gift_clear  <= 1'b0;
    end else begin
      start_btn_d <= start_btn;
      gift_clear  <= 1'b0;
      case (state)
        IDLE: begin
          if (start_rise) begin
            state      <= PLAY;
            gifts_left <= 4'(NUM_GIFTS);
            gift_seen  <= 1'b0;
          end
        end
        PLAY: begin
          if (win_evt) begin
            state <= WIN;
          end else if (expired) begin
            state <= LOSE;
          end else if (startOfFrame) begin
            // The latch restarts each frame; a coincident hit belongs to the new frame.
            gift_seen <= gift_hit;
            if (gift_seen && (gifts_left != 4'd0)) begin
              gifts_left <= gifts_left - 4'd1;
              gift_clear <= 1'b1;
            end
          end else if (gift_hit) begin
            gift_seen <= 1'b1;
          end
        end
        WIN, LOSE: begin
          if (start_rise)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gift_tracker_fsm.sv
// Scoreboard bench: stimulus queues expected snapshots tagged by cycle; a
// negedge monitor pops and compares them against one of two DUT configurations.
module tb_gift_tracker_fsm;

  logic clk = 1'b0;
  logic reset, startOfFrame, start_btn, gift_hit, hole_hit;

  logic       gc1, sh1, gc2, sh2;
  logic [3:0] gl1, gl2;
  logic [1:0] st1, st2;
  logic [6:0] tl1, tl2;

  always #5 clk = ~clk;

  gift_tracker_fsm #(.NUM_GIFTS(5), .FRAMES_PER_SEC(30), .TIME_LIMIT_SEC(60)) dut1 (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .start_btn(start_btn),
    .gift_hit(gift_hit), .hole_hit(hole_hit), .gift_clear(gc1), .gifts_left(gl1),
    .show_hole(sh1), .game_state(st1), .time_left(tl1)
  );

  gift_tracker_fsm #(.NUM_GIFTS(1), .FRAMES_PER_SEC(2), .TIME_LIMIT_SEC(3)) dut2 (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .start_btn(start_btn),
    .gift_hit(gift_hit), .hole_hit(hole_hit), .gift_clear(gc2), .gifts_left(gl2),
    .show_hole(sh2), .game_state(st2), .time_left(tl2)
  );

  typedef struct {
    int         cyc;
    int         dut;
    string      name;
    logic [1:0] st;
    logic [3:0] gl;
    logic [6:0] tl;
    logic       tl_chk;
    logic       gc;
    logic       sh;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    exp_t       r;
    logic [1:0] a_st;
    logic [3:0] a_gl;
    logic [6:0] a_tl;
    logic       a_gc, a_sh, ok;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      r = sb.pop_front();
      n_checks++;
      if (r.dut == 1) begin
        a_st = st1; a_gl = gl1; a_tl = tl1; a_gc = gc1; a_sh = sh1;
      end else begin
        a_st = st2; a_gl = gl2; a_tl = tl2; a_gc = gc2; a_sh = sh2;
      end
      ok = (r.cyc == cyc) && (a_st === r.st) && (a_gl === r.gl) &&
           (a_gc === r.gc) && (a_sh === r.sh) && (!r.tl_chk || (a_tl === r.tl));
      if (ok) n_pass++;
      else
        $display("FAIL %s dut%0d cyc%0d: got st=%0d gl=%0d tl=%0d gc=%0b sh=%0b, want st=%0d gl=%0d tl=%0d gc=%0b sh=%0b",
                 r.name, r.dut, cyc, a_st, a_gl, a_tl, a_gc, a_sh, r.st, r.gl, r.tl, r.gc, r.sh);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_st(input int d, input string nm, input logic [1:0] st,
                           input logic [3:0] gl, input logic [6:0] tl, input logic tl_chk,
                           input logic gc, input logic sh);
    exp_t r;
    r.cyc = cyc; r.dut = d; r.name = nm; r.st = st; r.gl = gl; r.tl = tl;
    r.tl_chk = tl_chk; r.gc = gc; r.sh = sh;
    sb.push_back(r);
  endtask

  task automatic sof();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
  endtask

  task automatic start_press();
    start_btn = 1'b1;
    tick();
    start_btn = 1'b0;
  endtask

  initial begin
    reset = 1'b1; startOfFrame = 1'b0; start_btn = 1'b0; gift_hit = 1'b0; hole_hit = 1'b0;
    tick();
    reset = 1'b0;
    expect_st(1, "reset_state", 2'd0, 4'd0, 7'd0, 1'b1, 1'b0, 1'b0);
    expect_st(2, "reset_state", 2'd0, 4'd0, 7'd0, 1'b1, 1'b0, 1'b0);

    // Held start button loads exactly once.
    start_btn = 1'b1;
    tick();
    expect_st(1, "start_load", 2'd1, 4'd5, 7'd60, 1'b1, 1'b0, 1'b0);
    repeat (99) tick();
    expect_st(1, "start_held", 2'd1, 4'd5, 7'd60, 1'b1, 1'b0, 1'b0);
    start_btn = 1'b0;

    // Long gift overlap within one frame counts once.
    gift_hit = 1'b1;
    repeat (200) tick();
    gift_hit = 1'b0;
    expect_st(1, "gift_no_comb", 2'd1, 4'd5, 7'd60, 1'b1, 1'b0, 1'b0);
    sof();
    expect_st(1, "gift_dec", 2'd1, 4'd4, 7'd60, 1'b1, 1'b1, 1'b0);
    tick();
    expect_st(1, "gift_clear_1cyc", 2'd1, 4'd4, 7'd60, 1'b1, 1'b0, 1'b0);

    // Hit coinciding with the frame pulse belongs to the next frame.
    gift_hit = 1'b1;
    sof();
    gift_hit = 1'b0;
    expect_st(1, "coincident_hit", 2'd1, 4'd4, 7'd60, 1'b1, 1'b0, 1'b0);
    tick();
    sof();
    expect_st(1, "coincident_next", 2'd1, 4'd3, 7'd60, 1'b1, 1'b1, 1'b0);

    // 600 frames total = 20 seconds.
    startOfFrame = 1'b1;
    repeat (597) tick();
    startOfFrame = 1'b0;
    expect_st(1, "time_40", 2'd1, 4'd3, 7'd40, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    expect_st(1, "reset_midplay", 2'd0, 4'd0, 7'd0, 1'b1, 1'b0, 1'b0);

    // Collect all five gifts, then the hole.
    start_press();
    expect_st(1, "restart_load", 2'd1, 4'd5, 7'd60, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      gift_hit = 1'b1;
      tick();
      gift_hit = 1'b0;
      sof();
      expect_st(1, $sformatf("collect_%0d", k), 2'd1, 4'(5 - k), 7'd60, 1'b1, 1'b1, 1'b0);
    end
    hole_hit = 1'b1;
    tick();
    hole_hit = 1'b0;
    expect_st(1, "hole_ignored", 2'd1, 4'd1, 7'd60, 1'b1, 1'b0, 1'b0);
    gift_hit = 1'b1;
    tick();
    gift_hit = 1'b0;
    sof();
    expect_st(1, "collect_5", 2'd1, 4'd0, 7'd60, 1'b1, 1'b1, 1'b1);
    gift_hit = 1'b1;
    tick();
    sof();
    gift_hit = 1'b0;
    expect_st(1, "saturate_0", 2'd1, 4'd0, 7'd60, 1'b1, 1'b0, 1'b1);
    hole_hit = 1'b1;
    tick();
    hole_hit = 1'b0;
    expect_st(1, "win", 2'd2, 4'd0, 7'd60, 1'b1, 1'b0, 1'b0);
    gift_hit = 1'b1;
    hole_hit = 1'b1;
    sof();
    gift_hit = 1'b0;
    hole_hit = 1'b0;
    expect_st(1, "win_frozen", 2'd2, 4'd0, 7'd60, 1'b1, 1'b0, 1'b0);
    start_press();
    expect_st(1, "win_to_idle", 2'd0, 4'd0, 7'd60, 1'b1, 1'b0, 1'b0);
    tick();
    start_press();
    expect_st(1, "idle_to_play", 2'd1, 4'd5, 7'd60, 1'b1, 1'b0, 1'b0);

    // Short-timer configuration: timeout.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    expect_st(2, "reset2", 2'd0, 4'd0, 7'd0, 1'b1, 1'b0, 1'b0);
    start_press();
    expect_st(2, "load2", 2'd1, 4'd1, 7'd3, 1'b1, 1'b0, 1'b0);
    for (int f = 1; f <= 6; f++) begin
      sof();
      case (f)
        1: expect_st(2, "tmr_f1", 2'd1, 4'd1, 7'd3, 1'b1, 1'b0, 1'b0);
        2: expect_st(2, "tmr_f2", 2'd1, 4'd1, 7'd2, 1'b1, 1'b0, 1'b0);
        3: expect_st(2, "tmr_f3", 2'd1, 4'd1, 7'd2, 1'b1, 1'b0, 1'b0);
        4: expect_st(2, "tmr_f4", 2'd1, 4'd1, 7'd1, 1'b1, 1'b0, 1'b0);
        5: expect_st(2, "tmr_f5", 2'd1, 4'd1, 7'd1, 1'b1, 1'b0, 1'b0);
        default: expect_st(2, "tmr_lose", 2'd3, 4'd1, 7'd0, 1'b1, 1'b0, 1'b0);
      endcase
    end
    gift_hit = 1'b1;
    repeat (3) sof();
    gift_hit = 1'b0;
    expect_st(2, "lose_frozen", 2'd3, 4'd1, 7'd0, 1'b1, 1'b0, 1'b0);

    // Win on the same edge as the expiry tick.
    start_press();
    expect_st(2, "lose_to_idle", 2'd0, 4'd1, 7'd0, 1'b1, 1'b0, 1'b0);
    tick();
    start_press();
    expect_st(2, "reload2", 2'd1, 4'd1, 7'd3, 1'b1, 1'b0, 1'b0);
    gift_hit = 1'b1;
    tick();
    gift_hit = 1'b0;
    sof();
    expect_st(2, "gift2", 2'd1, 4'd0, 7'd3, 1'b1, 1'b1, 1'b1);
    for (int f = 2; f <= 5; f++) begin
      sof();
      expect_st(2, $sformatf("hole_f%0d", f), 2'd1, 4'd0, (f < 4) ? 7'd2 : 7'd1, 1'b1, 1'b0, 1'b1);
    end
    hole_hit = 1'b1;
    sof();
    hole_hit = 1'b0;
    expect_st(2, "win_over_lose", 2'd2, 4'd0, 7'd0, 1'b0, 1'b0, 1'b0);
    start_press();
    expect_st(2, "win2_to_idle", 2'd0, 4'd0, 7'd0, 1'b0, 1'b0, 1'b0);
    tick();
    start_press();
    expect_st(2, "replay2", 2'd1, 4'd1, 7'd3, 1'b1, 1'b0, 1'b0);
    sof();
    expect_st(2, "replay_f1", 2'd1, 4'd1, 7'd3, 1'b1, 1'b0, 1'b0);
    sof();
    expect_st(2, "replay_f2", 2'd1, 4'd1, 7'd2, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
    if (sb.size() > 0) begin
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
      n_checks++;
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
